mod_signal_monitor: RTL and testbench
=====================================

// Module: mod_signal_monitor
// PURPOSE
//  Receive-side checker for the modulated imager signals. Samples loopback copies of
//  CLK, CLKN and CLKL (async to USER_CLOCK) and measures one modulation period.
//  Reports period, CLK high time and CLK->CLKL phase offset in USER_CLOCK cycles,
//  plus a sticky CLK/CLKN overlap error. Results go to OK-board readout registers.
// PARAMETERS
//  CNT_W        16      width of all measurement counters/results
//  TIMEOUT_CYC  65535   USER_CLOCK cycles allowed in ARM or MEAS before abort
// PORTS
//  USER_CLOCK     in   1      sole clock
//  RESET_B        in   1      synchronous, active-low reset
//  MEAS_START     in   1      1-cycle pulse: begin one measurement
//  MOD_CLK_IN     in   1      loopback of CLK, asynchronous
//  MOD_CLKN_IN    in   1      loopback of CLKN, asynchronous
//  MOD_CLKL_IN    in   1      loopback of CLKL, asynchronous
//  PERIOD_CNT     out  CNT_W  cycles CLK rise -> next CLK rise
//  HIGH_CNT       out  CNT_W  cycles CLK rise -> CLK fall
//  PHASE_CNT      out  CNT_W  cycles CLK rise -> first CLKL rise; all-ones if none
//  MEAS_VALID     out  1      1-cycle pulse, results updated this cycle
//  MEAS_TIMEOUT   out  1      1-cycle pulse, measurement aborted
//  OVERLAP_ERR    out  1      sticky: CLK and CLKN sampled high together in MEAS
//  BUSY           out  1      high in ARM or MEAS
// BEHAVIOUR
//  - Reset (RESET_B=0 at edge): state IDLE; every output 0; counters 0. Reset
//    mid-measurement aborts with no VALID/TIMEOUT pulse.
//  - Each input: 2-FF synchronizer then registered edge detect; rise/fall strobes
//    lag the pin by 3 cycles. Measurements are relative, so lag cancels.
//  - FSM IDLE->ARM->MEAS->DONE->IDLE:
//    IDLE: on MEAS_START: clear OVERLAP_ERR and timer, go ARM. Else hold.
//    ARM : on CLK rise strobe go MEAS; cnt<=1. If CLKL rise same cycle, phase
//          captured as 0. Timer==TIMEOUT_CYC-1 -> TIMEOUT pulse, go IDLE.
//    MEAS: cnt increments per cycle (saturates all-ones, no wrap).
//          CLK fall: HIGH capture<=cnt. First CLKL rise: PHASE capture<=cnt.
//          CLK rise: PERIOD capture<=cnt, go DONE. Timeout as in ARM.
//          CLK&CLKN (synced) both 1 -> OVERLAP_ERR<=1 (held until next START).
//    DONE: transfer captures to PERIOD/HIGH/PHASE_CNT, MEAS_VALID=1 one cycle,
//          go IDLE. CLKL absent all period -> PHASE_CNT=all-ones.
//  - Simultaneous strobes in MEAS: CLK rise and CLKL rise same cycle -> period
//    ends; CLKL not counted (phase = prior capture or all-ones).
//  - MEAS_START outside IDLE ignored. START coincident with reset: reset wins.
//  - On timeout, result outputs keep previous values; OVERLAP_ERR kept.
//  - Result outputs change only in DONE; stable otherwise.
// STRUCTURE
//  - Shared package (mod_sig_pkg): FSM state encodings (IDLE=0,ARM=1,MEAS=2,DONE=3),
//    PHASE_NONE all-ones constant, default CNT_W.
//  - Sub-module mod_edge_sync (2-FF sync + rise/fall strobes), instantiated 3x.
//  - Top: FSM, one shared cycle counter, timeout timer, capture regs, outputs.
// TESTING
//  1 USER_CLOCK 100MHz, CLK 1MHz 50%, CLKL 90deg, START -> VALID, PERIOD=100,
//    HIGH=50, PHASE=25, OVERLAP_ERR=0.
//  2 CLK 1MHz duty 25%, CLKN nonoverlapping, CLKL 0deg -> PERIOD=100, HIGH=25,
//    PHASE=0.
//  3 CLK stuck low, TIMEOUT_CYC=200 -> MEAS_TIMEOUT exactly 200 cycles after START,
//    BUSY falls, result outputs unchanged from prior run.
//  4 CLKN forced high 10 cycles overlapping CLK high -> OVERLAP_ERR=1, stays 1 after
//    VALID; next START clears it.
//  5 CLKL held low, CLK 1MHz -> VALID with PHASE_CNT=16'hFFFF, PERIOD=100.
//  6 RESET_B low mid-MEAS -> outputs 0 next cycle, no VALID; START pulsed while
//    BUSY ignored (single VALID per START).

Source files
------------

// File: rtl/mod_sig_pkg.sv
// Purpose: shared types and constants for the modulated-signal monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, default counter width, "no CLKL edge" phase marker.
package mod_sig_pkg;

  // Default width of every measurement counter and result register.
  localparam int CNT_W_DEF = 16;

  // Phase result reported when no CLKL rise was seen inside the period.
  // Kept wide; users slice it down to their counter width.
  localparam logic [63:0] PHASE_NONE = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mod_edge_sync.sv
// Purpose: bring one asynchronous loopback signal into the clock domain and strobe its edges.
// Latency: rise/fall strobes and the level output lag the pin by 3 clock cycles.
// Backpressure: none; free-running, strobes are single-cycle.
// Ports:
//   clk, rst_n     clock and synchronous active-low reset
//   sig_in         asynchronous input pin
//   lvl            synchronized level, aligned with the strobes
//   rise, fall     1-cycle edge strobes
module mod_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    // sync3 is the previous synchronized value; it also serves as the level
    // output so that level and strobes describe the same cycle.
    sync3_d = sync2_q;
    rise_d  = sync2_q & ~sync3_q;
    fall_d  = ~sync2_q & sync3_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign lvl  = sync3_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/mod_signal_monitor.sv
// Purpose: measure one period, CLK high time and CLK->CLKL phase of the looped-back imager clocks.
// Latency: results and MEAS_VALID appear the cycle after the closing CLK rise strobe (pins + 3 cycles).
// Backpressure: none; MEAS_START is ignored while a measurement is in flight.
// Ports:
//   USER_CLOCK, RESET_B                      clock, synchronous active-low reset
//   MEAS_START                               1-cycle request for one measurement
//   MOD_CLK_IN, MOD_CLKN_IN, MOD_CLKL_IN     asynchronous loopback inputs
//   PERIOD_CNT, HIGH_CNT, PHASE_CNT          result registers (all-ones phase = no CLKL edge)
//   MEAS_VALID, MEAS_TIMEOUT                 1-cycle completion / abort pulses
//   OVERLAP_ERR                              sticky CLK/CLKN overlap flag, cleared on start
//   BUSY                                     measurement in progress
module mod_signal_monitor
  import mod_sig_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             USER_CLOCK,
  input  logic             RESET_B,
  input  logic             MEAS_START,
  input  logic             MOD_CLK_IN,
  input  logic             MOD_CLKN_IN,
  input  logic             MOD_CLKL_IN,
  output logic [CNT_W-1:0] PERIOD_CNT,
  output logic [CNT_W-1:0] HIGH_CNT,
  output logic [CNT_W-1:0] PHASE_CNT,
  output logic             MEAS_VALID,
  output logic             MEAS_TIMEOUT,
  output logic             OVERLAP_ERR,
  output logic             BUSY
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] NO_PHASE   = PHASE_NONE[CNT_W-1:0];
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC - 1);

  logic clk_lvl, clk_rise, clk_fall;
  logic clkn_lvl, clkn_rise_unused, clkn_fall_unused;
  logic clkl_lvl_unused, clkl_rise, clkl_fall_unused;

  mod_edge_sync u_sync_clk (
    .clk   (USER_CLOCK),
    .rst_n (RESET_B),
    .sig_in(MOD_CLK_IN),
    .lvl   (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  mod_edge_sync u_sync_clkn (
    .clk   (USER_CLOCK),
    .rst_n (RESET_B),
    .sig_in(MOD_CLKN_IN),
    .lvl   (clkn_lvl),
    .rise  (clkn_rise_unused),
    .fall  (clkn_fall_unused)
  );

  mod_edge_sync u_sync_clkl (
    .clk   (USER_CLOCK),
    .rst_n (RESET_B),
    .sig_in(MOD_CLKL_IN),
    .lvl   (clkl_lvl_unused),
    .rise  (clkl_rise),
    .fall  (clkl_fall_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] high_cap_q, high_cap_d;
  logic [CNT_W-1:0] phase_cap_q, phase_cap_d;
  logic             phase_seen_q, phase_seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic             overlap_q, overlap_d;
  logic             timeout_hit;

  assign timeout_hit = (timer_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    timer_d      = timer_q;
    high_cap_d   = high_cap_q;
    phase_cap_d  = phase_cap_q;
    phase_seen_d = phase_seen_q;
    period_d     = period_q;
    high_d       = high_q;
    phase_d      = phase_q;
    overlap_d    = overlap_q;

    unique case (state_q)
      ST_IDLE: begin
        if (MEAS_START) begin
          overlap_d = 1'b0;
          timer_d   = '0;
          state_d   = ST_ARM;
        end
      end

      ST_ARM: begin
        timer_d = timer_q + 1'b1;
        if (timeout_hit) begin
          state_d = ST_IDLE;
        end else if (clk_rise) begin
          // The rise cycle itself is count 0, so the next cycle reads 1.
          state_d      = ST_MEAS;
          cnt_d        = {{(CNT_W-1){1'b0}}, 1'b1};
          high_cap_d   = '0;
          phase_seen_d = clkl_rise;
          phase_cap_d  = clkl_rise ? '0 : NO_PHASE;
        end
      end

      ST_MEAS: begin
        timer_d = timer_q + 1'b1;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (clk_lvl && clkn_lvl) begin
          overlap_d = 1'b1;
        end
        if (timeout_hit) begin
          state_d = ST_IDLE;
        end else if (clk_rise) begin
          // Period closes here; a CLKL rise in this same cycle belongs to the
          // next period and is deliberately not captured.
          period_d = cnt_q;
          high_d   = high_cap_q;
          phase_d  = phase_cap_q;
          state_d  = ST_DONE;
        end else begin
          if (clk_fall) begin
            high_cap_d = cnt_q;
          end
          if (clkl_rise && !phase_seen_q) begin
            phase_cap_d  = cnt_q;
            phase_seen_d = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge USER_CLOCK) begin
    if (!RESET_B) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      high_cap_q   <= '0;
      phase_cap_q  <= '0;
      phase_seen_q <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      phase_q      <= '0;
      overlap_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      high_cap_q   <= high_cap_d;
      phase_cap_q  <= phase_cap_d;
      phase_seen_q <= phase_seen_d;
      period_q     <= period_d;
      high_q       <= high_d;
      phase_q      <= phase_d;
      overlap_q    <= overlap_d;
    end
  end

  // Result registers are loaded on entry to DONE, so they are already new
  // during the MEAS_VALID cycle.
  assign PERIOD_CNT   = period_q;
  assign HIGH_CNT     = high_q;
  assign PHASE_CNT    = phase_q;
  assign OVERLAP_ERR  = overlap_q;
  assign MEAS_VALID   = (state_q == ST_DONE);
  assign BUSY         = (state_q == ST_ARM) || (state_q == ST_MEAS);
  assign MEAS_TIMEOUT = BUSY && timeout_hit;

endmodule

// File: tb/tb_mod_signal_monitor.sv
module tb_mod_signal_monitor;

  logic        USER_CLOCK = 1'b0;
  logic        RESET_B;
  logic        MEAS_START;
  logic        MOD_CLK_IN, MOD_CLKN_IN, MOD_CLKL_IN;
  logic [15:0] PERIOD_CNT, HIGH_CNT, PHASE_CNT;
  logic        MEAS_VALID, MEAS_TIMEOUT, OVERLAP_ERR, BUSY;

  int checks = 0;
  int errors = 0;

  // Waveform generator: one CLK period = per USER_CLOCK cycles, stepped on negedge.
  int ph = 0;
  int per = 100;
  int hi = 50;
  int lph = 25;
  bit clk_stuck = 0;
  bit clkl_off = 0;
  bit ovl_on = 0;

  always #5 USER_CLOCK = ~USER_CLOCK;

  always @(negedge USER_CLOCK) ph <= (ph >= per - 1) ? 0 : ph + 1;

  assign MOD_CLK_IN  = !clk_stuck && (ph < hi);
  assign MOD_CLKN_IN = ((ph > hi) && (ph < per - 1)) || (ovl_on && ph >= 10 && ph < 20);
  assign MOD_CLKL_IN = !clkl_off && (((ph - lph + per) % per) < hi);

  mod_signal_monitor #(.CNT_W(16), .TIMEOUT_CYC(200)) dut (
    .USER_CLOCK  (USER_CLOCK),
    .RESET_B     (RESET_B),
    .MEAS_START  (MEAS_START),
    .MOD_CLK_IN  (MOD_CLK_IN),
    .MOD_CLKN_IN (MOD_CLKN_IN),
    .MOD_CLKL_IN (MOD_CLKL_IN),
    .PERIOD_CNT  (PERIOD_CNT),
    .HIGH_CNT    (HIGH_CNT),
    .PHASE_CNT   (PHASE_CNT),
    .MEAS_VALID  (MEAS_VALID),
    .MEAS_TIMEOUT(MEAS_TIMEOUT),
    .OVERLAP_ERR (OVERLAP_ERR),
    .BUSY        (BUSY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse START a few cycles before a CLK rise so ARM is short; returns on the
  // negedge just after START was sampled.
  task automatic start_meas();
    for (int i = 0; i < 300; i++) begin
      @(posedge USER_CLOCK);
      if (ph == 94) break;
    end
    @(negedge USER_CLOCK);
    MEAS_START = 1'b1;
    @(negedge USER_CLOCK);
    MEAS_START = 1'b0;
  endtask

  task automatic wait_valid(output bit seen);
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge USER_CLOCK);
      if (MEAS_VALID) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    bit seen;
    int n;
    int vcnt;
    bit to_seen;
    bit v_during;

    RESET_B    = 1'b0;
    MEAS_START = 1'b0;
    repeat (3) @(negedge USER_CLOCK);
    chk("rst_period", PERIOD_CNT, 0);
    chk("rst_high", HIGH_CNT, 0);
    chk("rst_phase", PHASE_CNT, 0);
    chk("rst_valid", MEAS_VALID, 0);
    chk("rst_timeout", MEAS_TIMEOUT, 0);
    chk("rst_overlap", OVERLAP_ERR, 0);
    chk("rst_busy", BUSY, 0);
    RESET_B = 1'b1;
    repeat (5) @(negedge USER_CLOCK);

    // 1: 50% duty, CLKL at 90 degrees
    start_meas();
    chk("t1_busy", BUSY, 1);
    wait_valid(seen);
    chk("t1_valid", seen, 1);
    chk("t1_period", PERIOD_CNT, 100);
    chk("t1_high", HIGH_CNT, 50);
    chk("t1_phase", PHASE_CNT, 25);
    chk("t1_overlap", OVERLAP_ERR, 0);
    @(negedge USER_CLOCK);
    chk("t1_valid_pulse", MEAS_VALID, 0);
    chk("t1_busy_end", BUSY, 0);

    // 2: 25% duty, CLKL in phase with CLK
    hi = 25;
    lph = 0;
    start_meas();
    wait_valid(seen);
    chk("t2_valid", seen, 1);
    chk("t2_period", PERIOD_CNT, 100);
    chk("t2_high", HIGH_CNT, 25);
    chk("t2_phase", PHASE_CNT, 0);

    // 3: CLK stuck low -> timeout 200 cycles after START
    clk_stuck = 1;
    repeat (10) @(negedge USER_CLOCK);
    MEAS_START = 1'b1;
    n = 0;
    to_seen = 0;
    v_during = 0;
    for (int i = 1; i <= 260; i++) begin
      @(negedge USER_CLOCK);
      if (i == 1) MEAS_START = 1'b0;
      if (MEAS_VALID) v_during = 1;
      if (MEAS_TIMEOUT) begin
        n = i;
        to_seen = 1;
        break;
      end
    end
    chk("t3_timeout_seen", to_seen, 1);
    chk("t3_timeout_cycle", n, 200);
    chk("t3_no_valid", v_during, 0);
    @(negedge USER_CLOCK);
    chk("t3_timeout_pulse", MEAS_TIMEOUT, 0);
    chk("t3_busy_fall", BUSY, 0);
    chk("t3_period_kept", PERIOD_CNT, 100);
    chk("t3_high_kept", HIGH_CNT, 25);
    chk("t3_phase_kept", PHASE_CNT, 0);

    // 4: CLKN forced high during CLK high -> sticky overlap
    clk_stuck = 0;
    hi = 50;
    lph = 25;
    ovl_on = 1;
    start_meas();
    wait_valid(seen);
    chk("t4_valid", seen, 1);
    chk("t4_overlap", OVERLAP_ERR, 1);
    chk("t4_period", PERIOD_CNT, 100);
    ovl_on = 0;
    repeat (20) @(negedge USER_CLOCK);
    chk("t4_overlap_sticky", OVERLAP_ERR, 1);
    start_meas();
    chk("t4_overlap_clear", OVERLAP_ERR, 0);
    wait_valid(seen);
    chk("t4_valid2", seen, 1);
    chk("t4_overlap_clean", OVERLAP_ERR, 0);

    // 5: CLKL absent -> phase all-ones
    clkl_off = 1;
    start_meas();
    wait_valid(seen);
    chk("t5_valid", seen, 1);
    chk("t5_phase_none", PHASE_CNT, 16'hFFFF);
    chk("t5_period", PERIOD_CNT, 100);
    chk("t5_high", HIGH_CNT, 50);

    // 6: reset mid-measurement, then START while busy is ignored
    clkl_off = 0;
    start_meas();
    repeat (50) @(negedge USER_CLOCK);
    chk("t6_busy_mid", BUSY, 1);
    RESET_B = 1'b0;
    @(negedge USER_CLOCK);
    chk("t6_rst_period", PERIOD_CNT, 0);
    chk("t6_rst_high", HIGH_CNT, 0);
    chk("t6_rst_phase", PHASE_CNT, 0);
    chk("t6_rst_busy", BUSY, 0);
    chk("t6_rst_valid", MEAS_VALID, 0);
    RESET_B = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge USER_CLOCK);
      if (MEAS_VALID || MEAS_TIMEOUT) vcnt++;
    end
    chk("t6_no_pulse_after_rst", vcnt, 0);

    start_meas();
    repeat (20) @(negedge USER_CLOCK);
    MEAS_START = 1'b1;
    @(negedge USER_CLOCK);
    MEAS_START = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge USER_CLOCK);
      if (MEAS_VALID) vcnt++;
    end
    chk("t6_single_valid", vcnt, 1);
    chk("t6_period", PERIOD_CNT, 100);
    chk("t6_phase", PHASE_CNT, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
